fir_axil_master: RTL and testbench



---
 rtl/fir_axil_master.sv | 215 +++++++++++++++++++++
 tb/tb_fir_axil_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axil_master.sv
// AXI4-Lite initiator that loads taps into the FIR peripheral and runs one
// sample at a time through it: write sample, poll status, read result.
module fir_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int ADDR_NUMTAPS       = 0,
  parameter int ADDR_TAPS          = 1,
  parameter int ADDR_SAMPLE        = 2,
  parameter int ADDR_STATUS        = 0,
  parameter int ADDR_RESULT        = 1,
  parameter int MAX_POLLS          = 1024
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [15:0]                       cfg_num_taps,
  input  logic                              tap_valid,
  output logic                              tap_ready,
  input  logic [15:0]                       tap_data,
  input  logic                              smp_valid,
  output logic                              smp_ready,
  input  logic [15:0]                       smp_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [15:0]                       res_data,
  output logic                              configured,
  output logic                              err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, CFG_N, CFG_TAP, SMP_WR, POLL, RES_RD, OUT} state_t;

  state_t          state_reg;
  logic            awvalid_reg, wvalid_reg, bready_reg, wr_busy_reg;
  logic            arvalid_reg, rready_reg;
  logic [AW-1:0]   awaddr_reg, araddr_reg;
  logic [DW-1:0]   wdata_reg;
  logic            res_valid_reg, configured_reg, err_reg;
  logic [15:0]     res_data_reg, num_taps_reg, tap_cnt_reg;
  logic [PW-1:0]   poll_cnt_reg;

  logic b_hs, r_hs, aw_done, w_done;
  logic unused_rdata;

  assign b_hs    = M_AXI_BVALID && bready_reg;
  assign r_hs    = M_AXI_RVALID && rready_reg;
  assign aw_done = !awvalid_reg || M_AXI_AWREADY;
  assign w_done  = !wvalid_reg || M_AXI_WREADY;
  assign unused_rdata = ^M_AXI_RDATA[DW-1:16];

  assign cfg_ready = (state_reg == IDLE) && S_AXI_ARESETN;
  // A pending configuration wins over a simultaneous sample.
  assign smp_ready = (state_reg == IDLE) && S_AXI_ARESETN && configured_reg && !cfg_valid;
  assign tap_ready = (state_reg == CFG_TAP) && !wr_busy_reg && (tap_cnt_reg != num_taps_reg);

  assign res_valid     = res_valid_reg;
  assign res_data      = res_data_reg;
  assign configured    = configured_reg;
  assign err           = err_reg;
  assign M_AXI_AWADDR  = awaddr_reg;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARADDR  = araddr_reg;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = rready_reg;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_reg      <= IDLE;
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      bready_reg     <= 1'b0;
      wr_busy_reg    <= 1'b0;
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      awaddr_reg     <= '0;
      araddr_reg     <= '0;
      wdata_reg      <= '0;
      res_valid_reg  <= 1'b0;
      res_data_reg   <= '0;
      configured_reg <= 1'b0;
      err_reg        <= 1'b0;
      num_taps_reg   <= '0;
      tap_cnt_reg    <= '0;
      poll_cnt_reg   <= '0;
    end else begin
      // Channel bookkeeping; launches in the state case below override these.
      if (awvalid_reg && M_AXI_AWREADY) awvalid_reg <= 1'b0;
      if (wvalid_reg && M_AXI_WREADY)   wvalid_reg  <= 1'b0;
      if (wr_busy_reg && !bready_reg && aw_done && w_done) bready_reg <= 1'b1;
      if (b_hs) begin
        bready_reg  <= 1'b0;
        wr_busy_reg <= 1'b0;
        if (M_AXI_BRESP != 2'b00) err_reg <= 1'b1;
      end
      if (arvalid_reg && M_AXI_ARREADY) begin
        arvalid_reg <= 1'b0;
        rready_reg  <= 1'b1;
      end
      if (r_hs) begin
        rready_reg <= 1'b0;
        if (M_AXI_RRESP != 2'b00) err_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_num_taps == 16'd0) begin
              err_reg <= 1'b1;
            end else begin
              num_taps_reg   <= cfg_num_taps;
              configured_reg <= 1'b0;
              awvalid_reg    <= 1'b1;
              wvalid_reg     <= 1'b1;
              wr_busy_reg    <= 1'b1;
              awaddr_reg     <= AW'(ADDR_NUMTAPS);
              wdata_reg      <= DW'(cfg_num_taps);
              state_reg      <= CFG_N;
            end
          end else if (smp_valid && configured_reg) begin
            awvalid_reg <= 1'b1;
            wvalid_reg  <= 1'b1;
            wr_busy_reg <= 1'b1;
            awaddr_reg  <= AW'(ADDR_SAMPLE);
            wdata_reg   <= DW'(smp_data);
            state_reg   <= SMP_WR;
          end
        end
        CFG_N: begin
          if (b_hs) begin
            tap_cnt_reg <= '0;
            state_reg   <= CFG_TAP;
          end
        end
        CFG_TAP: begin
          if (tap_valid && tap_ready) begin
            tap_cnt_reg <= tap_cnt_reg + 16'd1;
            awvalid_reg <= 1'b1;
            wvalid_reg  <= 1'b1;
            wr_busy_reg <= 1'b1;
            awaddr_reg  <= AW'(ADDR_TAPS);
            wdata_reg   <= DW'(tap_data);
          end
          if (b_hs && tap_cnt_reg == num_taps_reg) begin
            configured_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        SMP_WR: begin
          if (b_hs) begin
            poll_cnt_reg <= '0;
            arvalid_reg  <= 1'b1;
            araddr_reg   <= AW'(ADDR_STATUS);
            state_reg    <= POLL;
          end
        end
        POLL: begin
          if (r_hs) begin
            if (M_AXI_RDATA[0]) begin
              arvalid_reg <= 1'b1;
              araddr_reg  <= AW'(ADDR_RESULT);
              state_reg   <= RES_RD;
            end else if (poll_cnt_reg == PW'(MAX_POLLS - 1)) begin
              err_reg   <= 1'b1;
              state_reg <= IDLE;
            end else begin
              poll_cnt_reg <= poll_cnt_reg + PW'(1);
              arvalid_reg  <= 1'b1;
              araddr_reg   <= AW'(ADDR_STATUS);
            end
          end
        end
        RES_RD: begin
          if (r_hs) begin
            res_data_reg  <= M_AXI_RDATA[15:0];
            res_valid_reg <= 1'b1;
            state_reg     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_axil_master.sv
// Directed bench for fir_axil_master with a behavioural AXI4-Lite FIR slave.
module tb_fir_axil_master;

  localparam int MAXP = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_valid, cfg_ready, tap_valid, tap_ready, smp_valid, smp_ready;
  logic [15:0] cfg_num_taps, tap_data, smp_data, res_data;
  logic        res_valid, res_ready, configured, err;
  logic [5:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  fir_axil_master #(.MAX_POLLS(MAXP)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_num_taps(cfg_num_taps),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_data(tap_data),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .configured(configured), .err(err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Slave knobs, written only by the stimulus process
  int aw_delay = 0;
  int status_zero = 0;
  bit never_done = 1'b0;
  int bresp_err_idx = -1;

  // Slave state and transaction logs
  int          aw_cnt, polls, tap_idx;
  logic        aw_have, w_have;
  logic [5:0]  aw_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;
  logic [15:0] tap0, sample;
  logic [5:0]  wlog_a[$];
  logic [31:0] wlog_d[$];
  logic [3:0]  wlog_s[$];
  logic [5:0]  rlog_a[$];

  assign awready = (aw_cnt >= aw_delay);
  assign wready  = 1'b1;
  assign arready = 1'b1;

  function automatic logic [15:0] fir1(input logic [15:0] t, input logic [15:0] s);
    logic signed [31:0] p;
    p = $signed(t) * $signed(s);
    return p[30:15];
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      aw_have <= 1'b0; w_have <= 1'b0; aw_cnt <= 0;
    end else begin
      if (awvalid && awready) begin
        aw_have <= 1'b1; aw_a <= awaddr; aw_cnt <= 0;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_have <= 1'b1; w_d <= wdata; w_s <= wstrb;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (aw_have && w_have && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= (wlog_a.size() == bresp_err_idx) ? 2'b10 : 2'b00;
        aw_have <= 1'b0; w_have <= 1'b0;
        wlog_a.push_back(aw_a); wlog_d.push_back(w_d); wlog_s.push_back(w_s);
        $display("  AXI write addr=%0d data=0x%04h strb=%h", aw_a, w_d, w_s);
        if (aw_a == 6'd0) tap_idx <= 0;
        else if (aw_a == 6'd1) begin
          if (tap_idx == 0) tap0 <= w_d[15:0];
          tap_idx <= tap_idx + 1;
        end else if (aw_a == 6'd2) begin
          sample <= w_d[15:0]; polls <= 0;
        end
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rlog_a.push_back(araddr);
        if (araddr == 6'd0) begin
          rdata <= (!never_done && polls >= status_zero) ? 32'd1 : 32'd0;
          polls <= polls + 1;
        end else begin
          rdata <= {16'h0000, fir1(tap0, sample)};
        end
      end
    end
  end

  // Bus monitors; only ever read by the stimulus process
  int awv_cycles = 0, wv_cycles = 0, bready_early = 0, b_hs_cnt = 0, res_seen = 0;
  always @(posedge clk) begin
    if (awvalid) awv_cycles <= awv_cycles + 1;
    if (wvalid) wv_cycles <= wv_cycles + 1;
    if (rstn && bready && (awvalid || wvalid)) bready_early <= bready_early + 1;
    if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
    if (res_valid) res_seen <= res_seen + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic send_cfg(input logic [15:0] n);
    int g = 0;
    @(negedge clk); cfg_num_taps = n; cfg_valid = 1'b1;
    while (!cfg_ready && g < 200) begin @(negedge clk); g++; end
    check("cfg_handshake", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk); cfg_valid = 1'b0;
  endtask

  task automatic send_tap(input logic [15:0] d);
    int g = 0;
    tap_data = d; tap_valid = 1'b1;
    while (!tap_ready && g < 200) begin @(negedge clk); g++; end
    check("tap_handshake", {31'd0, tap_ready}, 32'd1);
    @(negedge clk); tap_valid = 1'b0;
  endtask

  task automatic send_smp(input logic [15:0] d);
    int g = 0;
    @(negedge clk); smp_data = d; smp_valid = 1'b1;
    while (!smp_ready && g < 200) begin @(negedge clk); g++; end
    check("smp_handshake", {31'd0, smp_ready}, 32'd1);
    @(negedge clk); smp_valid = 1'b0;
  endtask

  task automatic recv_res(input string tag, input logic [15:0] exp, input int hold);
    int g = 0;
    while (!res_valid && g < 200) begin @(negedge clk); g++; end
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, res_data}, {16'd0, exp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
      check({tag, "_hold_data"}, {16'd0, res_data}, {16'd0, exp});
      check({tag, "_no_smp_ready"}, {31'd0, smp_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    check({tag, "_consumed"}, {31'd0, res_valid}, 32'd0);
  endtask

  task automatic config3();
    int g = 0;
    send_cfg(16'd3);
    send_tap(16'h4000);
    send_tap(16'h0000);
    send_tap(16'h0000);
    while (!configured && g < 200) begin @(negedge clk); g++; end
    check("configured", {31'd0, configured}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0;
    @(negedge clk);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, bb, br, ba, bwv, bs, g;
    rstn = 1'b0; cfg_valid = 1'b0; cfg_num_taps = '0; tap_valid = 1'b0; tap_data = '0;
    smp_valid = 1'b0; smp_data = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("rst_configured", {31'd0, configured}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_awvalid", {31'd0, awvalid}, 32'd0);
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("idle_smp_ready", {31'd0, smp_ready}, 32'd0);

    // Configuration: 3 taps
    bw = wlog_a.size(); bb = b_hs_cnt;
    config3();
    check("cfg_b_count", b_hs_cnt - bb, 32'd4);
    check("cfg_nwrites", wlog_a.size() - bw, 32'd4);
    check("cfg_w0_addr", {26'd0, wlog_a[bw]}, 32'd0);
    check("cfg_w0_data", wlog_d[bw], 32'd3);
    check("cfg_w1_addr", {26'd0, wlog_a[bw+1]}, 32'd1);
    check("cfg_w1_data", wlog_d[bw+1], 32'h4000);
    check("cfg_w2_data", wlog_d[bw+2], 32'h0000);
    check("cfg_w3_addr", {26'd0, wlog_a[bw+3]}, 32'd1);
    check("cfg_w3_data", wlog_d[bw+3], 32'h0000);
    check("cfg_wstrb", {28'd0, wlog_s[bw+3]}, 32'hF);
    check("cfg_err", {31'd0, err}, 32'd0);

    // Sample 0x1234 with two not-done polls; result held 5 cycles
    status_zero = 2; bw = wlog_a.size(); br = rlog_a.size();
    send_smp(16'h1234);
    recv_res("smp1234", 16'h091A, 5);
    check("smp1234_waddr", {26'd0, wlog_a[bw]}, 32'd2);
    check("smp1234_wdata", wlog_d[bw], 32'h1234);
    check("smp1234_nreads", rlog_a.size() - br, 32'd4);
    check("smp1234_first_rd", {26'd0, rlog_a[br]}, 32'd0);
    check("smp1234_last_rd", {26'd0, rlog_a[br+3]}, 32'd1);

    // AWREADY delayed 3 cycles, WREADY immediate
    aw_delay = 3; status_zero = 0; ba = awv_cycles; bwv = wv_cycles; bw = wlog_a.size();
    send_smp(16'hFF00);
    recv_res("awdelay", 16'hFF80, 0);
    aw_delay = 0;
    check("awdelay_awvalid_cycles", awv_cycles - ba, 32'd4);
    check("awdelay_wvalid_cycles", wv_cycles - bwv, 32'd1);
    check("awdelay_wdata", wlog_d[bw], 32'hFF00);
    check("bready_early", bready_early, 32'd0);

    // Seven not-done polls, done on the eighth (last allowed) read
    status_zero = 7; br = rlog_a.size();
    send_smp(16'h0100);
    recv_res("poll8", 16'h0080, 0);
    check("poll8_nreads", rlog_a.size() - br, 32'd9);
    check("poll8_last_rd", {26'd0, rlog_a[br+8]}, 32'd1);
    check("poll8_err", {31'd0, err}, 32'd0);

    // Status never sets: timeout after MAXP reads
    never_done = 1'b1; br = rlog_a.size(); bs = res_seen;
    send_smp(16'h0200);
    g = 0;
    while (!cfg_ready && g < 500) begin @(negedge clk); g++; end
    check("timeout_idle", {31'd0, cfg_ready}, 32'd1);
    check("timeout_nreads", rlog_a.size() - br, MAXP);
    check("timeout_err", {31'd0, err}, 32'd1);
    check("timeout_no_result", res_seen - bs, 32'd0);
    never_done = 1'b0;

    // BRESP=SLVERR on the second tap write
    do_reset();
    check("rst2_err", {31'd0, err}, 32'd0);
    check("rst2_configured", {31'd0, configured}, 32'd0);
    bw = wlog_a.size(); bresp_err_idx = bw + 2;
    config3();
    bresp_err_idx = -1;
    check("slverr_err", {31'd0, err}, 32'd1);
    check("slverr_nwrites", wlog_a.size() - bw, 32'd4);

    // Reset while the status read address is being presented
    do_reset();
    config3();
    never_done = 1'b1;
    send_smp(16'h0300);
    g = 0;
    while (!(arvalid && araddr == 6'd0) && g < 200) begin @(negedge clk); g++; end
    check("poll_ar_seen", {31'd0, arvalid}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_arvalid", {31'd0, arvalid}, 32'd0);
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_configured", {31'd0, configured}, 32'd0);
    check("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    rstn = 1'b1; never_done = 1'b0;
    @(negedge clk);
    check("postrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    // num_taps = 0 is rejected and the block stays idle
    send_cfg(16'd0);
    check("zero_taps_err", {31'd0, err}, 32'd1);
    check("zero_taps_idle", {31'd0, cfg_ready}, 32'd1);
    check("zero_taps_configured", {31'd0, configured}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
